// File: rtl/tdm_demux_rx_if.sv
// tdm_demux_rx_if: bundle between a TDM sample source and the demux receiver.
//   in_data/in_valid/in_sof : one slot per beat from the serializer
//   out_data                : N channel registers, channel k at [k*W +: W]
//   out_valid               : one-hot write strobe per channel
//   frame_done/sync_err     : frame-complete and alignment-loss pulses
//   locked                  : receiver is frame-aligned
// master = the source/consumer side, slave = the receiver.
interface tdm_demux_rx_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_sof;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           frame_done;
  logic           sync_err;
  logic           locked;

  modport master (
    output in_data, in_valid, in_sof,
    input  out_data, out_valid, frame_done, sync_err, locked
  );
  modport slave (
    input  in_data, in_valid, in_sof,
    output out_data, out_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: TDM demultiplexer, receive side.
//   Takes one channel sample per valid beat (slot 0 marked by in_sof) and
//   steers it into that channel's output register. A slot counter plus a
//   HUNT/LOCKED FSM tracks frame alignment; frame_done pulses when the last
//   slot lands, sync_err pulses on an early or missing start-of-frame.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - tdm_demux_rx_if.slave (sample stream in, channel registers out)
// All outputs are registered; a beat taken on edge t shows after edge t.

// Per-channel holding register: loads when its slot is written, else holds.
module tdm_demux_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= din;
  end
endmodule

module tdm_demux_rx #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux_rx_if.slave     bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N-1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              state, nxt_state;
  logic [SW-1:0]       slot, nxt_slot;
  logic [N-1:0]        wr_sel;
  logic                fd_nxt, se_nxt;
  logic [N-1:0]        ov_q;
  logic                fd_q, se_q, lock_q;
  logic [N-1:0][W-1:0] lane_q;

  // Beat decode: which channel (if any) this beat writes and where the
  // alignment tracker goes next.
  always_comb begin
    wr_sel    = '0;
    nxt_state = state;
    nxt_slot  = slot;
    fd_nxt    = 1'b0;
    se_nxt    = 1'b0;
    if (bus.in_valid) begin
      if (state == HUNT) begin
        // Non-SOF beats while hunting are dropped without complaint.
        if (bus.in_sof) begin
          wr_sel[0] = 1'b1;
          nxt_slot  = SW'(1);
          nxt_state = LOCKED;
        end
      end else if (bus.in_sof) begin
        // SOF always restarts the frame; arriving mid-frame is an error but
        // the beat is still accepted as slot 0.
        se_nxt    = (slot != '0);
        wr_sel[0] = 1'b1;
        nxt_slot  = SW'(1);
      end else if (slot == '0) begin
        // Expected SOF never came: alignment is lost.
        se_nxt    = 1'b1;
        nxt_state = HUNT;
      end else begin
        wr_sel[slot] = 1'b1;
        if (slot == LAST) begin
          fd_nxt   = 1'b1;
          nxt_slot = '0;
        end else begin
          nxt_slot = slot + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HUNT;
      slot   <= '0;
      ov_q   <= '0;
      fd_q   <= 1'b0;
      se_q   <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      slot   <= nxt_slot;
      ov_q   <= wr_sel;
      fd_q   <= fd_nxt;
      se_q   <= se_nxt;
      lock_q <= (nxt_state == LOCKED);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    tdm_demux_lane #(.W(W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (wr_sel[k]),
      .din (bus.in_data),
      .q   (lane_q[k])
    );
  end

  assign bus.out_data   = lane_q;
  assign bus.out_valid  = ov_q;
  assign bus.frame_done = fd_q;
  assign bus.sync_err   = se_q;
  assign bus.locked     = lock_q;
endmodule

// File: tb/tb_tdm_demux_rx.sv
module tb_tdm_demux_rx;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tdm_demux_rx_if #(.W(W), .N(N)) bus ();

  tdm_demux_rx #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame position as an integer, channel contents as an array.
  bit           m_lock;
  int           m_pos;
  logic [W-1:0] m_ch [N];
  logic [N-1:0] e_ov;
  bit           e_fd, e_se;

  task automatic model_step(input bit r, input bit v, input bit sof, input logic [W-1:0] d);
    e_ov = '0; e_fd = 0; e_se = 0;
    if (r) begin
      m_lock = 0; m_pos = 0;
      for (int k = 0; k < N; k++) m_ch[k] = '0;
    end else if (v) begin
      if (sof) begin
        if (m_lock && m_pos != 0) e_se = 1;
        m_lock = 1; m_ch[0] = d; e_ov = 1; m_pos = 1;
      end else if (m_lock) begin
        if (m_pos == 0) begin
          e_se = 1; m_lock = 0;
        end else begin
          m_ch[m_pos] = d;
          e_ov = N'(1) << m_pos;
          if (m_pos == N-1) begin e_fd = 1; m_pos = 0; end
          else m_pos++;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit sof, input logic [W-1:0] d);
    logic [N*W-1:0] exp_d;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.in_sof = sof; bus.in_data = d;
    @(posedge clk);
    model_step(r, v, sof, d);
    #1;
    for (int k = 0; k < N; k++) exp_d[k*W +: W] = m_ch[k];
    chk("out_data",   64'(bus.out_data),   64'(exp_d));
    chk("out_valid",  64'(bus.out_valid),  64'(e_ov));
    chk("frame_done", 64'(bus.frame_done), 64'(e_fd));
    chk("sync_err",   64'(bus.sync_err),   64'(e_se));
    chk("locked",     64'(bus.locked),     64'(m_lock));
  endtask

  task automatic beat(input bit sof, input logic [W-1:0] d);
    cycle(0, 1, sof, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, W'($urandom));
  endtask

  initial begin
    bus.in_valid = 0; bus.in_sof = 0; bus.in_data = '0;
    m_lock = 0; m_pos = 0;
    for (int k = 0; k < N; k++) m_ch[k] = '0;

    // 1: reset then two clean back-to-back frames
    cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 8'hEE);
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < N; s++) beat(s == 0, W'(8'hA0 + s + 16*f));

    // 2: hunting drops non-SOF beats silently
    cycle(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) beat(0, W'(8'h30 + i));
    beat(1, 8'h11);

    // 3: early SOF at slot 3, then finish the restarted frame
    beat(0, 8'h21); beat(0, 8'h22);
    beat(1, 8'h55);
    beat(0, 8'h61); beat(0, 8'h62); beat(0, 8'h63);

    // 4: missing SOF at slot 0 drops lock
    beat(0, 8'h77);
    idle(1);

    // 5: frame with 0..3 idle cycles between beats
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < N; s++) begin
        beat(s == 0, W'(8'hC0 + s + 16*f));
        idle(s);
      end

    // 6: reset at slot 2 (with a valid beat present), then relock
    beat(1, 8'h90); beat(0, 8'h91);
    cycle(1, 1, 0, 8'h92);
    for (int s = 0; s < N; s++) beat(s == 0, W'(8'hD0 + s));

    // Random: mostly well-formed frames with occasional SOF faults, gaps, resets
    begin
      int src_pos = 0;
      for (int i = 0; i < 3000; i++) begin
        bit v, sof, r;
        r = ($urandom_range(0, 299) == 0);
        v = ($urandom_range(0, 3) != 0);
        sof = (src_pos == 0) ^ ($urandom_range(0, 15) == 0);
        if (v) src_pos = (src_pos + 1) % N;
        cycle(r, v, sof, W'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
